// File: rtl/pacman_mm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | pacman_mm_pkg                                                  |
// | Shared memory-map constants and VRAM arbiter state encoding.   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package pacman_mm_pkg;

  localparam int VRAM_ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GPU_XFER = 2'd1,
    CPU_XFER = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/pacman_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | pacman_vram_arbiter                                            |
// | Single-port VRAM arbiter: GPU priority, CPU starvation bound.  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module pacman_vram_arbiter
  import pacman_mm_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = VRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait_n,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  output logic              gpu_ack,
  output logic [7:0]        gpu_rdata,
  output logic              vram_en,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_dout
);

  localparam int c_cnt_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_starve_cnt;
  logic [c_cnt_w-1:0] w_starve_nxt;
  logic               r_cpu_done;
  logic               w_cpu_done_nxt;
  logic               w_cpu_elig;
  logic               w_gpu_win;
  logic               w_cpu_win;

  // A completed CPU access stays blocked until the CPU releases its request.
  assign w_cpu_elig = cpu_req & ~r_cpu_done;
  assign w_gpu_win  = gpu_req & (~w_cpu_elig | (r_starve_cnt < c_starve_max));
  assign w_cpu_win  = w_cpu_elig & ~w_gpu_win;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_cpu_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_cpu_done   <= w_cpu_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_starve_nxt   = r_starve_cnt;
    w_cpu_done_nxt = r_cpu_done;
    vram_en        = 1'b0;
    vram_we        = 1'b0;
    vram_addr      = gpu_addr;
    gpu_ack        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gpu_win) begin
          vram_en     = 1'b1;
          w_state_nxt = GPU_XFER;
          // A GPU win over an eligible CPU implies the count is below the cap.
          if (w_cpu_elig) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
          end
        end else if (w_cpu_win) begin
          vram_en      = 1'b1;
          vram_we      = cpu_we;
          vram_addr    = cpu_addr;
          w_state_nxt  = CPU_XFER;
          w_starve_nxt = '0;
        end
      end
      GPU_XFER: begin
        gpu_ack     = 1'b1;
        w_state_nxt = IDLE;
      end
      CPU_XFER: begin
        w_cpu_done_nxt = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (!cpu_req) begin
      w_starve_nxt   = '0;
      w_cpu_done_nxt = 1'b0;
    end
    // Keep the BRAM quiet while reset is held, even with requests pending.
    if (!reset_n) begin
      vram_en = 1'b0;
      vram_we = 1'b0;
    end
  end

  assign vram_wdata = cpu_wdata;
  assign cpu_rdata  = vram_dout;
  assign gpu_rdata  = vram_dout;
  assign cpu_wait_n = ~cpu_req | r_cpu_done | (r_state == CPU_XFER);

endmodule
`default_nettype wire
